// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C address-detect slice: FSM encoding and bus widths.
package i2c_pkg;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_BYTE_WIDTH = 8;
  localparam int I2C_CNT_WIDTH  = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ACK      = 3'd2,
    SELECTED = 3'd3,
    IGNORE   = 3'd4
  } i2c_state_e;

endpackage

// File: rtl/i2c_sync_ff.sv
// Multi-flop synchronizer for one asynchronous I2C pin; resets to 1 so the bus looks idle.
module i2c_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  // Shift the raw pin level one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchronizer chain register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/i2c_addr_detect.sv
// I2C slave address detector: finds START/STOP, shifts in the address byte,
// ACKs a match and holds selected_o for the downstream data stage.
module i2c_addr_detect
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  input  logic [I2C_ADDR_WIDTH-1:0] slave_address_i,
  output logic                      sda_oe_o,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      addr_match_o,
  output logic                      rw_o,
  output logic                      selected_o
);

  logic scl_cur, sda_cur;
  logic scl_prev_q, sda_prev_q;
  logic start_det, stop_det, scl_rise, scl_fall;

  i2c_state_e                state_d, state_q;
  logic [I2C_CNT_WIDTH-1:0]  cnt_d, cnt_q;
  logic [I2C_BYTE_WIDTH-1:0] shift_d, shift_q;
  logic start_d, start_q, stop_d, stop_q, match_d, match_q;
  logic rw_d, rw_q, oe_d, oe_q, sel_d, sel_q;

  i2c_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_scl (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(scl_i), .q_o(scl_cur)
  );

  i2c_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sda (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sda_i), .q_o(sda_cur)
  );

  // An SDA edge coinciding with an SCL edge fails the scl_prev/scl_cur terms, so it is neither.
  assign start_det = scl_prev_q & scl_cur & sda_prev_q & ~sda_cur;
  assign stop_det  = scl_prev_q & scl_cur & ~sda_prev_q & sda_cur;
  assign scl_rise  = ~scl_prev_q & scl_cur;
  assign scl_fall  = scl_prev_q & ~scl_cur;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    match_d = 1'b0;
    rw_d    = rw_q;
    oe_d    = oe_q;
    sel_d   = sel_q;
    if (start_det) begin
      start_d = 1'b1;
      cnt_d   = '0;
      oe_d    = 1'b0;
      sel_d   = 1'b0;
      state_d = ADDR;
    end else if (stop_det) begin
      stop_d  = 1'b1;
      oe_d    = 1'b0;
      sel_d   = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[I2C_BYTE_WIDTH-2:0], sda_cur};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              // General call (7'h00) never matches, including an unconfigured address.
              if ((shift_d[I2C_BYTE_WIDTH-1:1] == slave_address_i) &&
                  (slave_address_i != 7'h00)) begin
                state_d = ACK;
                match_d = 1'b1;
                rw_d    = shift_d[0];
              end else begin
                state_d = IGNORE;
              end
            end else begin
              state_d = ADDR;
            end
          end else begin
            state_d = ADDR;
          end
        end
        ACK: begin
          // First fall starts driving the ACK, the fall after the 9th high releases it.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              sel_d   = 1'b1;
              state_d = SELECTED;
            end
          end else begin
            oe_d = oe_q;
          end
        end
        IDLE, SELECTED, IGNORE: state_d = state_q;
        default:                state_d = IDLE;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      match_q    <= 1'b0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      scl_prev_q <= scl_cur;
      sda_prev_q <= sda_cur;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      match_q    <= match_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      sel_q      <= sel_d;
    end
  end

  assign sda_oe_o     = oe_q;
  assign start_o      = start_q;
  assign stop_o       = stop_q;
  assign addr_match_o = match_q;
  assign rw_o         = rw_q;
  assign selected_o   = sel_q;

endmodule

// File: tb/tb_i2c_addr_detect.sv
// Directed bench for i2c_addr_detect: bit-banged I2C master with hand-computed expectations.
module tb_i2c_addr_detect;

  localparam int PH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic [6:0] addr = 7'h00;
  logic       sda_oe_o, start_o, stop_o, addr_match_o, rw_o, selected_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0, n_stop = 0, n_match = 0, n_oe = 0, n_stop_bad = 0;
  int b_start, b_stop, b_match, b_oe, b_stop_bad;
  int lat;

  i2c_addr_detect #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda),
    .slave_address_i(addr), .sda_oe_o(sda_oe_o), .start_o(start_o),
    .stop_o(stop_o), .addr_match_o(addr_match_o), .rw_o(rw_o),
    .selected_o(selected_o)
  );

  always #5 clk = ~clk;

  // Count cycles each output is high, sampled away from the active edge.
  always @(negedge clk) begin
    if (start_o) n_start++;
    if (stop_o) n_stop++;
    if (addr_match_o) n_match++;
    if (sda_oe_o) n_oe++;
    if (stop_o && (sda_oe_o || selected_o)) n_stop_bad++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold();
    repeat (PH) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_start = n_start; b_stop = n_stop; b_match = n_match;
    b_oe = n_oe; b_stop_bad = n_stop_bad;
  endtask

  task automatic i2c_start(output int latency);
    sda = 1'b1; hold();
    scl = 1'b1; hold();
    sda = 1'b0;
    latency = 0;
    do begin
      @(posedge clk); #1;
      latency++;
    end while (!start_o && latency < 10);
    hold();
    scl = 1'b0; hold();
  endtask

  task automatic i2c_stop();
    sda = 1'b0; hold();
    scl = 1'b1; hold();
    sda = 1'b1; hold();
  endtask

  task automatic send_bit(input logic b);
    sda = b;    hold();
    scl = 1'b1; hold();
    scl = 1'b0; hold();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  initial begin
    // Reset state
    hold(); hold();
    chk_eq("rst_oe", sda_oe_o, 1'b0);
    chk_eq("rst_start", start_o, 1'b0);
    chk_eq("rst_stop", stop_o, 1'b0);
    chk_eq("rst_match", addr_match_o, 1'b0);
    chk_eq("rst_rw", rw_o, 1'b0);
    chk_eq("rst_sel", selected_o, 1'b0);
    rst = 1'b0; hold();

    // Matched write to 7'h55 with full ACK clock
    addr = 7'h55; snap();
    i2c_start(lat);
    chk_eq("t1_start_lat", lat, 3);
    send_byte(8'hAA);
    chk_eq("t1_match_cnt", n_match - b_match, 1);
    chk_eq("t1_rw", rw_o, 1'b0);
    chk_eq("t1_oe_after_fall", sda_oe_o, 1'b1);
    sda = 1'b1; hold();
    scl = 1'b1; hold();
    chk_eq("t1_oe_9th_high", sda_oe_o, 1'b1);
    chk_eq("t1_sel_9th_high", selected_o, 1'b0);
    scl = 1'b0; hold();
    chk_eq("t1_oe_released", sda_oe_o, 1'b0);
    chk_eq("t1_selected", selected_o, 1'b1);
    i2c_stop();
    chk_eq("t1_start_cnt", n_start - b_start, 1);
    chk_eq("t1_stop_cnt", n_stop - b_stop, 1);
    chk_eq("t1_sel_after_stop", selected_o, 1'b0);

    // Address 7'h54 must be ignored
    snap();
    i2c_start(lat);
    send_byte(8'hA9);
    sda = 1'b1; hold(); scl = 1'b1; hold(); scl = 1'b0; hold();
    chk_eq("t2_match_cnt", n_match - b_match, 0);
    chk_eq("t2_oe_cycles", n_oe - b_oe, 0);
    i2c_stop();
    chk_eq("t2_stop_cnt", n_stop - b_stop, 1);
    chk_eq("t2_sel", selected_o, 1'b0);

    // Partial byte, repeated START, then read from 7'h55
    snap();
    i2c_start(lat);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_start(lat);
    send_byte(8'hAB);
    chk_eq("t3_start_cnt", n_start - b_start, 2);
    chk_eq("t3_match_cnt", n_match - b_match, 1);
    chk_eq("t3_rw", rw_o, 1'b1);
    sda = 1'b1; hold(); scl = 1'b1; hold(); scl = 1'b0; hold();
    chk_eq("t3_selected", selected_o, 1'b1);
    i2c_stop();

    // STOP inside the ACK slot after a match
    snap();
    i2c_start(lat);
    send_byte(8'hAA);
    chk_eq("t6_rw", rw_o, 1'b0);
    sda = 1'b0; hold();
    scl = 1'b1; hold();
    chk_eq("t6_oe_before_stop", sda_oe_o, 1'b1);
    sda = 1'b1; hold();
    chk_eq("t6_stop_cnt", n_stop - b_stop, 1);
    chk_eq("t6_stop_cycle_clean", n_stop_bad - b_stop_bad, 0);
    chk_eq("t6_oe", sda_oe_o, 1'b0);
    chk_eq("t6_sel", selected_o, 1'b0);

    // Unconfigured address never matches a general call
    addr = 7'h00; snap();
    i2c_start(lat);
    send_byte(8'h00);
    sda = 1'b1; hold(); scl = 1'b1; hold(); scl = 1'b0; hold();
    chk_eq("t4_match_cnt", n_match - b_match, 0);
    chk_eq("t4_oe_cycles", n_oe - b_oe, 0);
    i2c_stop();

    // Reset during the 9th SCL high releases SDA at once
    addr = 7'h55;
    i2c_start(lat);
    send_byte(8'hAA);
    sda = 1'b1; hold(); scl = 1'b1; hold();
    chk_eq("t5_oe_pre_rst", sda_oe_o, 1'b1);
    rst = 1'b1; #1;
    chk_eq("t5_oe_async", sda_oe_o, 1'b0);
    hold();
    chk_eq("t5_sel_in_rst", selected_o, 1'b0);
    rst = 1'b0; hold();
    snap();
    scl = 1'b0; hold();
    for (int i = 0; i < 9; i++) send_bit(i[0]);
    chk_eq("t5_no_start", n_start - b_start, 0);
    chk_eq("t5_no_stop", n_stop - b_stop, 0);
    chk_eq("t5_no_match", n_match - b_match, 0);
    chk_eq("t5_no_oe", n_oe - b_oe, 0);
    chk_eq("t5_no_sel", selected_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
